// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer controller.
// Entry layout is fixed by the default PC/index widths below.
package btb_pkg;

  localparam int PC_W  = 16;
  localparam int IDX_W = 6;
  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef logic [1:0] cnt_t;

  localparam cnt_t SNT      = 2'd0;
  localparam cnt_t WNT      = 2'd1;
  localparam cnt_t WT       = 2'd2;
  localparam cnt_t ST       = 2'd3;
  localparam cnt_t CNT_INIT = WT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    cnt_t             cnt;
  } btb_entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } btb_state_t;

  // Two-bit saturating direction counter.
  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    cnt_t res;
    res = cnt;
    if (taken && cnt != ST)
      res = cnt + 2'd1;
    else if (!taken && cnt != SNT)
      res = cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/btb_mem.sv
// BTB entry array: two combinational read ports (fetch, update) and one
// synchronous write port.
module btb_mem
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] fetch_idx,
  output btb_entry_t       fetch_entry,
  input  logic [IDX_W-1:0] upd_idx,
  output btb_entry_t       upd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_entry;
  end

  assign fetch_entry = mem[fetch_idx];
  assign upd_entry   = mem[upd_idx];

endmodule

// File: rtl/btb_ctrl.sv
// Branch target buffer controller: fetch lookup, EX update sequencing,
// post-reset / enable-edge invalidate sweep and mispredict flush.
//
// state | meaning
// CLEAR | sweeping valid=0 over every index, updates blocked, busy=1
// RUN   | lookups and updates served; en rising edge restarts CLEAR
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int   PC_W     = btb_pkg::PC_W,
  parameter int   IDX_W    = btb_pkg::IDX_W,
  parameter cnt_t CNT_INIT = btb_pkg::CNT_INIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            flush,
  output logic [PC_W-1:0] flush_pc,
  output logic            busy
);

  btb_state_t       state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic             en_q;

  btb_entry_t       fetch_entry, upd_entry, wr_entry;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  logic [IDX_W-1:0]    fetch_idx, upd_idx;
  logic [PC_W-IDX_W-1:0] fetch_tag, upd_tag;
  logic                accept, upd_hit, mis;

  assign fetch_idx = if_pc[IDX_W-1:0];
  assign fetch_tag = if_pc[PC_W-1:IDX_W];
  assign upd_idx   = upd_pc[IDX_W-1:0];
  assign upd_tag   = upd_pc[PC_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      en_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      en_q      <= en;
      sweep_cnt <= (state == CLEAR) ? sweep_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (&sweep_cnt) state_nxt = RUN;
      RUN:     if (en && !en_q) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy      = (state == CLEAR);
    upd_ready = (state == RUN);
  end

  assign accept  = upd_valid & upd_ready;
  assign upd_hit = upd_entry.valid & (upd_entry.tag == upd_tag);
  assign mis     = (upd_taken != upd_pred_taken) |
                   (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));

  // Sweep owns the write port in CLEAR; writes are dropped while reset is held
  // so an in-flight update never lands.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = sweep_cnt;
    wr_entry = '0;
    if (rst_n) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (accept && en) begin
        wr_idx = upd_idx;
        if (upd_hit) begin
          wr_en        = 1'b1;
          wr_entry     = upd_entry;
          wr_entry.cnt = cnt_next(upd_entry.cnt, upd_taken);
          if (upd_taken)
            wr_entry.target = upd_target;
        end else if (upd_taken) begin
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = upd_tag;
          wr_entry.target = upd_target;
          wr_entry.cnt    = CNT_INIT;
        end
      end
    end
  end

  btb_mem u_mem (
    .clk         (clk),
    .fetch_idx   (fetch_idx),
    .fetch_entry (fetch_entry),
    .upd_idx     (upd_idx),
    .upd_entry   (upd_entry),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_entry    (wr_entry)
  );

  assign pred_taken  = (state == RUN) & en & fetch_entry.valid &
                       (fetch_entry.tag == fetch_tag) & fetch_entry.cnt[1];
  assign pred_target = pred_taken ? fetch_entry.target : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      flush <= accept & mis;
      if (accept && mis)
        flush_pc <= upd_taken ? upd_target : upd_pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl.
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_target;
  logic        flush;
  logic [15:0] flush_pc;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  btb_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [15:0] pc,
                      input logic exp_taken, input logic [15:0] exp_target);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    chk({tag, "_target"}, {16'd0, pred_target}, {16'd0, exp_target});
  endtask

  task automatic set_upd(input logic v, input logic [15:0] pc, input logic tk,
                         input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  // Counts cycles with busy high (bounded) and notes any flush seen meanwhile.
  task automatic count_busy(output int n, output bit saw_flush);
    n = 0;
    saw_flush = 1'b0;
    while (busy && n < 200) begin
      if (flush) saw_flush = 1'b1;
      tick();
      n++;
    end
  endtask

  int n_busy;
  bit saw_fl;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    if_pc = 16'h0000;
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) tick();

    // 1: reset state and initial sweep length
    chk("rst_busy",        {31'd0, busy},        32'd1);
    chk("rst_upd_ready",   {31'd0, upd_ready},   32'd0);
    chk("rst_pred_taken",  {31'd0, pred_taken},  32'd0);
    chk("rst_pred_target", {16'd0, pred_target}, 32'd0);
    chk("rst_flush",       {31'd0, flush},       32'd0);
    chk("rst_flush_pc",    {16'd0, flush_pc},    32'd0);
    rst_n = 1'b1;
    count_busy(n_busy, saw_fl);
    chk("init_busy_cycles", n_busy, 32'd64);
    chk("init_upd_ready",   {31'd0, upd_ready}, 32'd1);

    // 2: allocate 0x0045 -> 0x0100; same-cycle lookup sees old contents
    set_upd(1'b1, 16'h0045, 1'b1, 16'h0100, 1'b0, 16'h0000);
    look("alloc_same_cycle", 16'h0045, 1'b0, 16'h0000);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("alloc_flush",    {31'd0, flush},    32'd1);
    chk("alloc_flush_pc", {16'd0, flush_pc}, 32'h0100);
    look("alloc_hit", 16'h0045, 1'b1, 16'h0100);
    tick();
    chk("flush_one_cycle", {31'd0, flush},    32'd0);
    chk("flush_pc_hold",   {16'd0, flush_pc}, 32'h0100);

    // 3: three back-to-back not-taken updates: 2->1->0->0 (saturate low)
    set_upd(1'b1, 16'h0045, 1'b0, 16'h0000, 1'b1, 16'h0100);
    tick();
    chk("nt1_flush",    {31'd0, flush},    32'd1);
    chk("nt1_flush_pc", {16'd0, flush_pc}, 32'h0046);
    look("nt1_lookup", 16'h0045, 1'b0, 16'h0000);
    tick();
    chk("nt2_flush", {31'd0, flush}, 32'd1);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    look("nt3_sat0", 16'h0045, 1'b0, 16'h0000);
    // two taken updates: 0->1 (still not taken) -> 2 (taken)
    set_upd(1'b1, 16'h0045, 1'b1, 16'h0100, 1'b0, 16'h0000);
    tick();
    look("tk1_lookup", 16'h0045, 1'b0, 16'h0000);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    look("tk2_lookup", 16'h0045, 1'b1, 16'h0100);
    // correct predictions: 2->3->3 (saturate high), no flush
    set_upd(1'b1, 16'h0045, 1'b1, 16'h0100, 1'b1, 16'h0100);
    tick();
    chk("correct1_noflush", {31'd0, flush}, 32'd0);
    tick();
    chk("correct2_noflush", {31'd0, flush}, 32'd0);
    set_upd(1'b1, 16'h0045, 1'b0, 16'h0000, 1'b1, 16'h0100);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("sat3_flush_pc", {16'd0, flush_pc}, 32'h0046);
    look("sat3_lookup", 16'h0045, 1'b1, 16'h0100);
    // wrong target with correct direction
    set_upd(1'b1, 16'h0045, 1'b1, 16'h0100, 1'b1, 16'h0101);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("tgt_mis_flush",    {31'd0, flush},    32'd1);
    chk("tgt_mis_flush_pc", {16'd0, flush_pc}, 32'h0100);
    // fall-through PC wraps; miss and not taken writes nothing
    tick();
    set_upd(1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h1234);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("wrap_flush",    {31'd0, flush},    32'd1);
    chk("wrap_flush_pc", {16'd0, flush_pc}, 32'h0000);
    look("wrap_nowrite", 16'hFFFF, 1'b0, 16'h0000);

    // 4: aliasing at index 5, plus a second entry at index 7
    set_upd(1'b1, 16'h0085, 1'b1, 16'h0200, 1'b0, 16'h0000);
    tick();
    set_upd(1'b1, 16'h0107, 1'b1, 16'h0300, 1'b0, 16'h0000);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    look("alias_old", 16'h0045, 1'b0, 16'h0000);
    look("alias_new", 16'h0085, 1'b1, 16'h0200);
    tick();
    look("idx7_hit", 16'h0107, 1'b1, 16'h0300);

    // 5: en low blocks lookups and writes, flush still works
    en = 1'b0;
    look("en0_lookup", 16'h0085, 1'b0, 16'h0000);
    set_upd(1'b1, 16'h0085, 1'b1, 16'h0400, 1'b1, 16'h0200);
    #1;
    chk("en0_upd_ready", {31'd0, upd_ready}, 32'd1);
    tick();
    chk("en0_flush_pc1", {16'd0, flush_pc}, 32'h0400);
    set_upd(1'b1, 16'h0009, 1'b1, 16'h0500, 1'b0, 16'h0000);
    tick();
    chk("en0_flush_pc2", {16'd0, flush_pc}, 32'h0500);
    // en rises together with an accepted update
    en = 1'b1;
    set_upd(1'b1, 16'h0107, 1'b0, 16'h0000, 1'b1, 16'h0300);
    look("en0_nowrite", 16'h0085, 1'b1, 16'h0200);
    look("en0_noalloc", 16'h0009, 1'b0, 16'h0000);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("enrise_flush",    {31'd0, flush},    32'd1);
    chk("enrise_flush_pc", {16'd0, flush_pc}, 32'h0108);
    chk("enrise_ready",    {31'd0, upd_ready}, 32'd0);
    count_busy(n_busy, saw_fl);
    chk("enrise_busy_cycles", n_busy, 32'd64);
    look("swept_85", 16'h0085, 1'b0, 16'h0000);
    tick();
    look("swept_107", 16'h0107, 1'b0, 16'h0000);

    // 6: reset at sweep index 30 with an update pending
    rst_n = 1'b0;
    tick();
    chk("rst2_flush_pc", {16'd0, flush_pc}, 32'h0000);
    chk("rst2_busy",     {31'd0, busy},     32'd1);
    rst_n = 1'b1;
    repeat (30) tick();
    set_upd(1'b1, 16'h0010, 1'b1, 16'h0600, 1'b0, 16'h0000);
    #1;
    chk("midsweep_ready", {31'd0, upd_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(n_busy, saw_fl);
    chk("restart_busy_cycles", n_busy, 32'd64);
    chk("restart_no_flush",    {31'd0, saw_fl}, 32'd0);
    chk("held_upd_ready",      {31'd0, upd_ready}, 32'd1);
    tick();
    set_upd(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("held_flush",    {31'd0, flush},    32'd1);
    chk("held_flush_pc", {16'd0, flush_pc}, 32'h0600);
    look("held_alloc", 16'h0010, 1'b1, 16'h0600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Controller for the CPU's branch target buffer.
- Serves fetch-stage lookups and sequences EX-stage resolution updates into a single-write-port entry array (tag, target, valid, 2-bit saturating counter).
- Runs an invalidate sweep after reset and on each enable rising edge.
- Detects mispredictions and issues a one-cycle flush with the corrected PC.
- Sits between the fetch stage, the EX-stage branch unit and the `btb_mem` array; `en` comes from the board switch (SW[0]).

Parameters:
- PC_W, 16, PC / instruction address width (word-addressed)
- IDX_W, 6, index bits; DEPTH = 2**IDX_W entries
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low, sampled on rising edge of clk
- en  in  1  BTB enable (level)
- if_pc  in  PC_W  fetch PC
- pred_taken  out  1  predict taken for if_pc
- pred_target  out  PC_W  predicted target (0 when pred_taken=0)
- upd_valid  in  1  EX resolved a branch this cycle
- upd_ready  out  1  controller can accept an update
- upd_pc  in  PC_W  resolved branch PC
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  PC_W  predicted target carried down the pipe
- flush  out  1  mispredict pulse
- flush_pc  out  PC_W  corrected fetch PC
- busy  out  1  invalidate sweep in progress

Behaviour:
- Index and tag split: idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
- Reset values: pred_taken=0, pred_target=0, upd_ready=0, flush=0, flush_pc=0, busy=1. The state machine enters CLEAR with sweep counter = 0.
- Reset mid-sweep or mid-update restarts CLEAR at index 0. No partially applied update survives.
- State machine: CLEAR, RUN.
  - CLEAR: writes valid=0 to index sweep_cnt each cycle. busy=1, upd_ready=0, pred_taken=0.
  - CLEAR to RUN: after the write to index DEPTH-1, so busy lasts exactly DEPTH cycles.
  - RUN to CLEAR: on a registered en rising edge (en_q=0, en=1).
- Lookup (combinational, same cycle):
  - pred_taken = RUN & en & valid[idx] & tag match & cnt[1].
  - pred_target = stored target when pred_taken=1, else 0.
- Updates in RUN: upd_ready=1. An update is accepted when upd_valid & upd_ready. Its write commits at the end of the accepting cycle.
  - Hit (valid and tag match): counter +1 saturating at 3 if taken, -1 saturating at 0 if not taken. Target is rewritten only when taken.
  - Miss and taken: allocate entry with {valid=1, tag, upd_target, CNT_INIT}, overwriting the previous occupant.
  - Miss and not taken: no write.
- en=0 in RUN: updates are accepted (upd_ready=1) but nothing is written; flush logic still runs.
- Misprediction on an accepted update, mis = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)).
  - flush is registered: high for exactly the one cycle after acceptance.
  - flush_pc = upd_taken ? upd_target : upd_pc+1, with PC_W wrap (0xFFFF+1 = 0x0000).
  - flush_pc holds its last value while flush=0.
- Update arriving during CLEAR: not accepted (upd_ready=0), so no flush is produced. The upstream EX stage must hold upd_valid until accepted.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents; the new value is visible the next cycle.
- Back-to-back updates are accepted every cycle. Updates to the same index in consecutive cycles read-modify-write correctly (second sees first's result).
- en rising in the same cycle as an accepted update: the update commits, then CLEAR starts next cycle. Any flush still fires.

Decomposition:
- Package `btb_pkg`:
  - `btb_entry_t` struct {valid, tag, target, cnt}
  - `btb_state_t` enum {CLEAR, RUN}
  - counter constants SNT=0, WNT=1, WT=2, ST=3, and CNT_INIT
- Sub-module `btb_mem`: DEPTH x btb_entry_t array with two combinational read ports (fetch, update) and one synchronous write port. The write mux between sweep and update lives in `btb_ctrl`.

Test Plan:
1. Reset released with en=1 -> busy=1 for 64 cycles, upd_ready=0, pred_taken=0; cycle 65 busy=0, upd_ready=1.
2. Update pc=0x0045 taken target=0x0100 pred_taken=0 -> flush=1 next cycle, flush_pc=0x0100. Then if_pc=0x0045 -> pred_taken=1, pred_target=0x0100.
3. Same branch resolved not-taken twice with pred_taken=1 -> counter 2→1→0. First update gives flush with flush_pc=0x0046. if_pc=0x0045 -> pred_taken=0 after the first update.
4. Aliasing: allocate 0x0045, then taken update pc=0x0085 (same idx 5) target=0x0200 -> if_pc=0x0045 gives pred_taken=0, if_pc=0x0085 gives 0x0200.
5. en toggled 1→0→1 after trained entries -> while en=0 pred_taken=0 and updates do not write. On rising edge busy=1 for 64 cycles, after which all lookups miss.
6. Assert rst_n=0 at sweep index 30 while upd_valid=1 -> sweep restarts at 0, no flush, busy stays high for 64 cycles after release.
